// File: rtl/subservient_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | subservient_pkg - shared FSM encoding and byte-lane constants            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package subservient_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_RD      = 3'd2;
  localparam logic [2:0] ST_RD_LAST = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  localparam int IDX_W    = 2;
  localparam int WB_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WR      = ST_WR,
    S_RD      = ST_RD,
    S_RD_LAST = ST_RD_LAST,
    S_ACK     = ST_ACK
  } state_t;

endpackage
`default_nettype wire

// File: rtl/subservient_byte_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | subservient_byte_lane - picks the write byte, merges the read byte lane  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module subservient_byte_lane
  import subservient_pkg::*;
(
  input  logic [31:0]      wr_word,
  input  logic [IDX_W-1:0] wr_idx,
  output logic [7:0]       wr_byte,
  input  logic [31:0]      rd_word,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [7:0]       rd_byte,
  output logic [31:0]      rd_merged
);

  assign wr_byte = wr_word[{wr_idx, 3'b000} +: 8];

  for (genvar k = 0; k < WB_BYTES; k++) begin : g_lane
    assign rd_merged[8*k +: 8] = (rd_idx == IDX_W'(k)) ? rd_byte : rd_word[8*k +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/subservient_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | subservient_sram_arbiter - shares the byte SRAM between CPU and WB slave |
// | Option: SUBSERVIENT_ARB_DBG_MODE_EN adds i_debug_mode. Rev 1.0           |
// +--------------------------------------------------------------------------+
module subservient_sram_arbiter
  import subservient_pkg::*;
#(
  parameter int memsize = 512,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
`ifdef SUBSERVIENT_ARB_DBG_MODE_EN
  input  logic          i_debug_mode,
`endif
  input  logic [aw-1:0] i_cpu_waddr,
  input  logic [7:0]    i_cpu_wdata,
  input  logic          i_cpu_wen,
  input  logic [aw-1:0] i_cpu_raddr,
  input  logic          i_cpu_ren,
  output logic [7:0]    o_cpu_rdata,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_prev;
  logic             rd_pending;
  logic [aw-3:0]    word_adr;
  logic [31:0]      wr_word;
  logic [3:0]       sel;
  logic [31:0]      rd_word;

  logic             req;
  logic             wb_may;
  logic             cpu_wen_eff;
  logic             cpu_ren_eff;
  logic             wb_wr_slot;
  logic             wb_rd_slot;
  logic [7:0]       wr_byte;
  logic [31:0]      rd_merged;
  logic             unused_adr;

  assign req        = wbs_cyc_i & wbs_stb_i;
  assign unused_adr = &{1'b0, wbs_adr_i[31:aw], wbs_adr_i[1:0]};

`ifdef SUBSERVIENT_ARB_DBG_MODE_EN
  // Debug mode hands both ports to one side exclusively.
  assign wb_may      = i_debug_mode;
  assign cpu_wen_eff = i_cpu_wen & ~i_debug_mode;
  assign cpu_ren_eff = i_cpu_ren & ~i_debug_mode;
`else
  assign wb_may      = 1'b1;
  assign cpu_wen_eff = i_cpu_wen;
  assign cpu_ren_eff = i_cpu_ren;
`endif

  assign wb_wr_slot  = (state == S_WR) & wb_may & ~cpu_wen_eff;
  assign wb_rd_slot  = (state == S_RD) & wb_may & ~cpu_ren_eff;
  assign wbs_ack_o   = (state == S_ACK);
  assign o_cpu_rdata = i_sram_rdata;

  subservient_byte_lane u_lane (
    .wr_word   (wr_word),
    .wr_idx    (idx),
    .wr_byte   (wr_byte),
    .rd_word   (rd_word),
    .rd_idx    (idx_prev),
    .rd_byte   (i_sram_rdata),
    .rd_merged (rd_merged)
  );

  always_comb begin
    o_sram_waddr = '0;
    o_sram_wdata = '0;
    o_sram_wen   = 1'b0;
    o_sram_raddr = '0;
    o_sram_ren   = 1'b0;
    if (cpu_wen_eff) begin
      o_sram_waddr = i_cpu_waddr;
      o_sram_wdata = i_cpu_wdata;
      o_sram_wen   = 1'b1;
    end else if (wb_wr_slot) begin
      // A disabled byte still consumes its slot, just without a write strobe.
      o_sram_waddr = {word_adr, idx};
      o_sram_wdata = wr_byte;
      o_sram_wen   = sel[idx];
    end
    if (cpu_ren_eff) begin
      o_sram_raddr = i_cpu_raddr;
      o_sram_ren   = 1'b1;
    end else if (wb_rd_slot) begin
      o_sram_raddr = {word_adr, idx};
      o_sram_ren   = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      idx_prev   <= '0;
      rd_pending <= 1'b0;
      word_adr   <= '0;
      wr_word    <= '0;
      sel        <= '0;
      rd_word    <= '0;
      wbs_dat_o  <= '0;
    end else begin
      // Read data lags its issue by one cycle, so remember which lane it is for.
      rd_pending <= wb_rd_slot;
      idx_prev   <= idx;
      if (rd_pending) rd_word <= rd_merged;
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (req && wb_may) begin
            word_adr <= wbs_adr_i[aw-1:2];
            wr_word  <= wbs_dat_i;
            sel      <= wbs_sel_i;
            state    <= wbs_we_i ? S_WR : S_RD;
          end
        end
        S_WR: begin
          if (wb_wr_slot) idx <= idx + IDX_W'(1);
          if (!req)                                      state <= S_IDLE;
          else if (wb_wr_slot && idx == IDX_W'(WB_BYTES-1)) state <= S_ACK;
        end
        S_RD: begin
          if (wb_rd_slot) idx <= idx + IDX_W'(1);
          if (!req)                                      state <= S_IDLE;
          else if (wb_rd_slot && idx == IDX_W'(WB_BYTES-1)) state <= S_RD_LAST;
        end
        S_RD_LAST: begin
          if (!req) begin
            state <= S_IDLE;
          end else begin
            wbs_dat_o <= rd_merged;
            state     <= S_ACK;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_subservient_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_subservient_sram_arbiter - directed bench with a behavioural SRAM     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_subservient_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  cpu_waddr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_wen   = 1'b0;
  logic [8:0]  cpu_raddr = '0;
  logic        cpu_ren   = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [8:0]  sram_waddr, sram_raddr;
  logic [7:0]  sram_wdata;
  logic        sram_wen, sram_ren;
  logic [7:0]  sram_rdata = '0;
`ifdef SUBSERVIENT_ARB_DBG_MODE_EN
  logic        debug_mode = 1'b1;
`endif

  logic [7:0]  mem [512];
  logic [7:0]  cpu_seen [16];
  int          n_chk = 0;
  int          n_err = 0;
  int          wen_cnt = 0;

  always #5 clk = ~clk;

  subservient_sram_arbiter #(.memsize(512), .aw(9)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
`ifdef SUBSERVIENT_ARB_DBG_MODE_EN
    .i_debug_mode (debug_mode),
`endif
    .i_cpu_waddr  (cpu_waddr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_wen    (cpu_wen),
    .i_cpu_raddr  (cpu_raddr),
    .i_cpu_ren    (cpu_ren),
    .o_cpu_rdata  (cpu_rdata),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .o_sram_waddr (sram_waddr),
    .o_sram_wdata (sram_wdata),
    .o_sram_wen   (sram_wen),
    .o_sram_raddr (sram_raddr),
    .o_sram_ren   (sram_ren),
    .i_sram_rdata (sram_rdata)
  );

  // Behavioural 1W/1R SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (sram_wen) mem[sram_waddr] <= sram_wdata;
    if (sram_ren) sram_rdata <= mem[sram_raddr];
  end

  always @(negedge clk) if (sram_wen) wen_cnt = wen_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one Wishbone transfer; cpu_mask bit c drives a CPU read in cycle c.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [15:0] cpu_mask,
                         output int ack_cyc, output logic [31:0] rdat);
    ack_cyc = -1;
    rdat    = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    cpu_ren = cpu_mask[0]; cpu_raddr = 9'h1E;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 16) cpu_seen[c] = cpu_rdata;
      if (ack) begin
        ack_cyc = c;
        rdat    = dat_o;
        break;
      end
      @(posedge clk); #1;
      cpu_ren   = (c + 1 < 16) ? cpu_mask[c+1] : 1'b0;
      cpu_raddr = 9'(9'h1F + c);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cpu_ren = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          exp_ack;
    logic [31:0] exp_val;   // read data for reads, write-strobe count for writes
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          ack_cyc;
    int          wen0;
    logic [31:0] rdat;
    logic        seen;

    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    vecs[0] = '{"wr_10",   1'b1, 32'h0000_0010, 32'hA1B2C3D4, 4'hF, 5, 32'd4};
    vecs[1] = '{"rd_10",   1'b0, 32'h0000_0010, 32'h0,        4'hF, 6, 32'hA1B2C3D4};
    vecs[2] = '{"wr_20",   1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h5, 5, 32'd2};
    vecs[3] = '{"rd_20",   1'b0, 32'h0000_0020, 32'h0,        4'hF, 6, 32'h00FF00FF};
    vecs[4] = '{"wr_37",   1'b1, 32'h0000_0037, 32'h12345678, 4'hF, 5, 32'd4};
    vecs[5] = '{"rd_34",   1'b0, 32'h0000_0034, 32'h0,        4'hF, 6, 32'h12345678};
    vecs[6] = '{"rd_210",  1'b0, 32'hFFFF_FE10, 32'h0,        4'hF, 6, 32'hA1B2C3D4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_dat",   dat_o, 32'h0);
    chk("rst_sram",  {13'h0, sram_waddr, sram_raddr, sram_wen, sram_ren}, 32'h0);
    chk("rst_wdata", 32'(sram_wdata), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wen0 = wen_cnt;
      wb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, 16'h0, ack_cyc, rdat);
      chk({vecs[i].name, "_ack"}, 32'(ack_cyc), 32'(vecs[i].exp_ack));
      if (vecs[i].w) chk({vecs[i].name, "_wen"}, 32'(wen_cnt - wen0), vecs[i].exp_val);
      else           chk({vecs[i].name, "_dat"}, rdat, vecs[i].exp_val);
    end

    chk("mem_10_bytes", {mem[9'h13], mem[9'h12], mem[9'h11], mem[9'h10]}, 32'hA1B2C3D4);
    chk("mem_20_bytes", {mem[9'h23], mem[9'h22], mem[9'h21], mem[9'h20]}, 32'h00FF00FF);

    // WB read of 0x10 while the CPU reads 0x20..0x22 in cycles 2-4.
    wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, 16'b0000_0000_0001_1100, ack_cyc, rdat);
    chk("contend_ack", 32'(ack_cyc), 32'd9);
    chk("contend_dat", rdat, 32'hA1B2C3D4);
    chk("contend_cpu", {8'h0, cpu_seen[3], cpu_seen[4], cpu_seen[5]}, 32'h00FF00FF);

    // Reset during the byte-2 write slot.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; dat = 32'h11223344; sel = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_sram", {13'h0, sram_waddr, sram_raddr, sram_wen, sram_ren}, 32'h0);
    chk("midrst_ack_dat", {31'h0, ack} | dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_mem", {mem[9'h42], mem[9'h41], mem[9'h40]}, 32'h00_3344);
    wb_xfer(1'b0, 32'h40, 32'h0, 4'hF, 16'h0, ack_cyc, rdat);
    chk("postrst_ack", 32'(ack_cyc), 32'd6);
    chk("postrst_dat", rdat, 32'h00003344);

`ifdef SUBSERVIENT_ARB_DBG_MODE_EN
    debug_mode = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h50; dat = 32'h0A0B0C0D; sel = 4'hF;
    repeat (6) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("dbg_hold_ack", 32'(seen), 32'h0);
    debug_mode = 1'b1; cpu_wen = 1'b1; cpu_waddr = 9'h50; cpu_wdata = 8'hEE;
    ack_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack) begin ack_cyc = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cpu_wen = 1'b0;
    chk("dbg_ack", 32'(ack_cyc), 32'd5);
    chk("dbg_mem", {mem[9'h53], mem[9'h52], mem[9'h51], mem[9'h50]}, 32'h0A0B0C0D);
`else
    seen = 1'b0;
    chk("dbg_absent", 32'(seen), 32'h0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
